imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader_if.sv | 34 +++
 rtl/imem_boot_loader.sv | 200 ++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader_if
// Description : Host byte stream, instruction-memory write port and status
//               of the boot loader, bundled for a single port connection.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_boot_loader_if;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_wr;
    logic [63:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_run;
    logic [15:0] words_loaded;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, mem_wr, mem_waddr, mem_wdata,
        input  busy, done, error, cpu_run, words_loaded
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, mem_wr, mem_waddr, mem_wdata,
        output busy, done, error, cpu_run, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Assembles a length-prefixed byte stream into 32-bit words,
//               writes them to instruction memory, verifies the XOR checksum
//               and then releases the core via cpu_run.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              CLK,
    input  logic              RST,
    imem_boot_loader_if.slave bus
);

    localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_rx_ready;
    logic        r_busy;
    logic        r_mem_wr;
    logic [63:0] r_mem_waddr;
    logic [31:0] r_mem_wdata;
    logic        r_done;
    logic        r_error;
    logic        r_cpu_run;
    logic [15:0] r_words_loaded;
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_csum;
    logic [23:0] r_word_buf;

    logic        w_xfer;
    logic        w_sess_start;
    logic [15:0] w_n_hdr;
    logic        w_too_long;
    logic        w_last_byte;
    logic        w_last_word;
    logic        w_next_active;

    assign w_xfer       = bus.rx_valid & r_rx_ready;
    assign w_sess_start = bus.start & ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                       (r_state == ST_ERROR));
    assign w_n_hdr      = {bus.rx_data, r_len[7:0]};
    assign w_too_long   = ({1'b0, w_n_hdr} > c_max_words);
    assign w_last_byte  = (r_byte_idx == 2'd3);
    assign w_last_word  = (r_word_idx == (r_len - 16'd1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (w_sess_start) begin
                    w_next_state = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_xfer) begin
                    w_next_state = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (w_xfer) begin
                    if (w_too_long) begin
                        w_next_state = ST_ERROR;
                    end else if (w_n_hdr == 16'd0) begin
                        w_next_state = ST_CHECK;
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_xfer && w_last_byte && w_last_word) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_xfer) begin
                    w_next_state = (bus.rx_data == r_csum) ? ST_DONE : ST_ERROR;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // rx_ready and busy are registered copies of "next state is a receiving state"
    assign w_next_active = (w_next_state == ST_LEN_LO) || (w_next_state == ST_LEN_HI) ||
                           (w_next_state == ST_DATA)   || (w_next_state == ST_CHECK);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rx_ready     <= 1'b0;
            r_busy         <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_mem_waddr    <= BASE_ADDR;
            r_mem_wdata    <= 32'h0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_cpu_run      <= 1'b0;
            r_words_loaded <= 16'h0;
            r_len          <= 16'h0;
            r_word_idx     <= 16'h0;
            r_byte_idx     <= 2'd0;
            r_csum         <= 8'h0;
            r_word_buf     <= 24'h0;
        end else begin
            r_rx_ready <= w_next_active;
            r_busy     <= w_next_active;
            r_mem_wr   <= 1'b0;

            // The address moves on only after the write pulse has been presented
            if (r_mem_wr) begin
                r_mem_waddr <= r_mem_waddr + 64'd4;
            end

            if (w_sess_start) begin
                r_done         <= 1'b0;
                r_error        <= 1'b0;
                r_cpu_run      <= 1'b0;
                r_words_loaded <= 16'h0;
                r_csum         <= 8'h0;
                r_mem_waddr    <= BASE_ADDR;
                r_word_idx     <= 16'h0;
                r_byte_idx     <= 2'd0;
            end

            if (w_xfer) begin
                case (r_state)
                    ST_LEN_LO: r_len[7:0] <= bus.rx_data;
                    ST_LEN_HI: begin
                        r_len[15:8] <= bus.rx_data;
                        if (w_too_long) begin
                            r_error <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        r_csum <= r_csum ^ bus.rx_data;
                        case (r_byte_idx)
                            2'd0: r_word_buf[7:0]   <= bus.rx_data;
                            2'd1: r_word_buf[15:8]  <= bus.rx_data;
                            2'd2: r_word_buf[23:16] <= bus.rx_data;
                            default: begin
                                r_mem_wdata    <= {bus.rx_data, r_word_buf};
                                r_mem_wr       <= 1'b1;
                                r_words_loaded <= r_words_loaded + 16'd1;
                                r_word_idx     <= r_word_idx + 16'd1;
                            end
                        endcase
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                    ST_CHECK: begin
                        if (bus.rx_data == r_csum) begin
                            r_done    <= 1'b1;
                            r_cpu_run <= 1'b1;
                        end else begin
                            r_error   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready     = r_rx_ready;
    assign bus.busy         = r_busy;
    assign bus.mem_wr       = r_mem_wr;
    assign bus.mem_waddr    = r_mem_waddr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.done         = r_done;
    assign bus.error        = r_error;
    assign bus.cpu_run      = r_cpu_run;
    assign bus.words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Self-checking bench for imem_boot_loader: table-driven and
//               random load sessions against a stream-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam logic [63:0] c_base = 64'hFFFF_FFFF_FFFF_FFF0;
    localparam int          c_max  = 256;

    typedef struct {
        logic [63:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [15:0] n;
        bit          bad;
        int          gap;
        bit          start_mid;
        bit          exp_done;
        bit          exp_err;
        logic [15:0] exp_wl;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          n_checks;
    int          n_pass;
    bit          mon_en;
    wr_t         cap_q[$];
    logic [31:0] payload[$];
    vec_t        vecs[9];

    imem_boot_loader_if bif ();

    imem_boot_loader #(
        .BASE_ADDR (c_base),
        .MAX_WORDS (c_max)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && bif.mem_wr) begin
            cap_q.push_back('{a: bif.mem_waddr, d: bif.mem_wdata});
        end
        if (mon_en) begin
            check("done_error_exclusive", {63'h0, bif.done & bif.error}, 64'h0);
            check("cpu_run_tracks_done", {63'h0, bif.cpu_run}, {63'h0, bif.done});
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, {63'h0, bif.rx_ready}, 64'h0);
        check({tag, "_mem_wr"}, {63'h0, bif.mem_wr}, 64'h0);
        check({tag, "_mem_waddr"}, bif.mem_waddr, c_base);
        check({tag, "_mem_wdata"}, {32'h0, bif.mem_wdata}, 64'h0);
        check({tag, "_busy"}, {63'h0, bif.busy}, 64'h0);
        check({tag, "_done"}, {63'h0, bif.done}, 64'h0);
        check({tag, "_error"}, {63'h0, bif.error}, 64'h0);
        check({tag, "_cpu_run"}, {63'h0, bif.cpu_run}, 64'h0);
        check({tag, "_words_loaded"}, {48'h0, bif.words_loaded}, 64'h0);
    endtask

    task automatic pulse_start();
        bif.start    = 1'b1;
        bif.rx_valid = 1'b0;
        @(negedge clk);
        bif.start    = 1'b0;
    endtask

    // Presents one byte after an optional random idle gap; returns on the
    // falling edge following the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        while (($urandom_range(99) < gap) && (guard < 8)) begin
            bif.rx_valid = 1'b0;
            bif.rx_data  = 8'($urandom);
            @(negedge clk);
            guard++;
        end
        bif.rx_valid = 1'b1;
        bif.rx_data  = b;
        guard = 0;
        while (!bif.rx_ready && (guard < 50)) begin
            @(negedge clk);
            guard++;
        end
        if (!bif.rx_ready) begin
            check("rx_ready_timeout", {63'h0, bif.rx_ready}, 64'h1);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic run_session(input logic [15:0] n, input bit bad, input int gap,
                               input bit start_mid, input bit exp_done,
                               input bit exp_err, input logic [15:0] exp_wl);
        int          n_exp;
        logic [7:0]  cs;
        logic [31:0] w;
        cs    = 8'h0;
        n_exp = (int'(n) <= c_max) ? int'(n) : 0;
        for (int i = 0; i < n_exp; i++) begin
            w = payload[i];
            cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
        if (bad) begin
            cs = cs ^ 8'h01;
        end

        cap_q.delete();
        pulse_start();
        check("start_busy", {63'h0, bif.busy}, 64'h1);
        check("start_rx_ready", {63'h0, bif.rx_ready}, 64'h1);
        check("start_cpu_run", {63'h0, bif.cpu_run}, 64'h0);
        check("start_done", {63'h0, bif.done}, 64'h0);
        check("start_words_loaded", {48'h0, bif.words_loaded}, 64'h0);
        check("start_mem_waddr", bif.mem_waddr, c_base);

        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        if (int'(n) > c_max) begin
            check("hdr_reject_error", {63'h0, bif.error}, 64'h1);
            check("hdr_reject_rx_ready", {63'h0, bif.rx_ready}, 64'h0);
        end else begin
            for (int i = 0; i < n_exp; i++) begin
                w = payload[i];
                for (int k = 0; k < 4; k++) begin
                    send_byte(w[8*k +: 8], gap);
                    if (start_mid && (i == 0) && (k == 1)) begin
                        pulse_start();
                        check("start_mid_busy", {63'h0, bif.busy}, 64'h1);
                    end
                end
            end
            send_byte(cs, gap);
        end

        // Offered bytes must be refused once the session has finished
        bif.rx_valid = 1'b1;
        bif.rx_data  = 8'($urandom);
        repeat (4) @(negedge clk);
        bif.rx_valid = 1'b0;

        check("end_done", {63'h0, bif.done}, {63'h0, exp_done});
        check("end_error", {63'h0, bif.error}, {63'h0, exp_err});
        check("end_cpu_run", {63'h0, bif.cpu_run}, {63'h0, exp_done});
        check("end_words_loaded", {48'h0, bif.words_loaded}, {48'h0, exp_wl});
        check("end_busy", {63'h0, bif.busy}, 64'h0);
        check("end_rx_ready", {63'h0, bif.rx_ready}, 64'h0);
        check("write_count", 64'(cap_q.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < cap_q.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), cap_q[i].a, c_base + 64'(i) * 64'd4);
            check($sformatf("wr_data[%0d]", i), {32'h0, cap_q[i].d}, {32'h0, payload[i]});
        end
    endtask

    task automatic fill_random(input logic [15:0] n);
        payload.delete();
        if (int'(n) <= c_max) begin
            for (int i = 0; i < int'(n); i++) begin
                payload.push_back($urandom);
            end
        end
    endtask

    initial begin
        logic [15:0] rn;
        bit          rbad;
        n_checks     = 0;
        n_pass       = 0;
        mon_en       = 1'b0;
        rst_n        = 1'b0;
        bif.start    = 1'b0;
        bif.rx_valid = 1'b1;
        bif.rx_data  = 8'h55;

        vecs[0] = '{16'd1,   1'b0, 0,  1'b0, 1'b1, 1'b0, 16'd1};
        vecs[1] = '{16'd3,   1'b1, 30, 1'b0, 1'b0, 1'b1, 16'd3};
        vecs[2] = '{16'd0,   1'b0, 0,  1'b0, 1'b1, 1'b0, 16'd0};
        vecs[3] = '{16'd0,   1'b1, 20, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[4] = '{16'd300, 1'b0, 0,  1'b0, 1'b0, 1'b1, 16'd0};
        vecs[5] = '{16'd257, 1'b0, 10, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[6] = '{16'd256, 1'b0, 0,  1'b0, 1'b1, 1'b0, 16'd256};
        vecs[7] = '{16'd4,   1'b0, 60, 1'b1, 1'b1, 1'b0, 16'd4};
        vecs[8] = '{16'd2,   1'b0, 50, 1'b0, 1'b1, 1'b0, 16'd2};

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_rx_ready_with_valid", {63'h0, bif.rx_ready}, 64'h0);
        check("idle_no_writes", 64'(cap_q.size()), 64'h0);
        bif.rx_valid = 1'b0;
        mon_en = 1'b1;

        // Known 2-word image, good then corrupted checksum, then with gaps
        payload.delete();
        payload.push_back(32'h12345678);
        payload.push_back(32'hDEADBEEF);
        run_session(16'd2, 1'b0, 0, 1'b0, 1'b1, 1'b0, 16'd2);
        if (cap_q.size() == 2) begin
            check("known_word0", {32'h0, cap_q[0].d}, 64'h12345678);
            check("known_word1", {32'h0, cap_q[1].d}, 64'hDEADBEEF);
        end else begin
            check("known_write_count", 64'(cap_q.size()), 64'd2);
        end
        run_session(16'd2, 1'b1, 0, 1'b0, 1'b0, 1'b1, 16'd2);
        run_session(16'd2, 1'b0, 70, 1'b1, 1'b1, 1'b0, 16'd2);

        for (int v = 0; v < 9; v++) begin
            fill_random(vecs[v].n);
            run_session(vecs[v].n, vecs[v].bad, vecs[v].gap, vecs[v].start_mid,
                        vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_wl);
        end

        for (int r = 0; r < 8; r++) begin
            rn   = ($urandom_range(9) == 0) ? 16'(c_max + $urandom_range(1, 40))
                                            : 16'($urandom_range(0, 6));
            rbad = ($urandom_range(2) == 0);
            fill_random(rn);
            run_session(rn, rbad, $urandom_range(0, 60), 1'b0,
                        (int'(rn) <= c_max) && !rbad, (int'(rn) > c_max) || rbad,
                        (int'(rn) <= c_max) ? rn : 16'd0);
        end

        // Reset after six payload bytes: word 0 written, word 1 not
        payload.delete();
        payload.push_back(32'hA1B2C3D4);
        payload.push_back(32'h0F1E2D3C);
        cap_q.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hD4, 0);
        send_byte(8'hC3, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hA1, 0);
        send_byte(8'h3C, 0);
        send_byte(8'h2D, 0);
        bif.rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        check("midrst_write_count", 64'(cap_q.size()), 64'd1);
        if (cap_q.size() > 0) begin
            check("midrst_word0", {32'h0, cap_q[0].d}, 64'hA1B2C3D4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_session(16'd2, 1'b0, 0, 1'b0, 1'b1, 1'b0, 16'd2);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
